// File: rtl/axis_pkg.sv
// Shared state encoding and keep-mask helpers for the AXI-Stream header inserter.
package axis_pkg;

   localparam int AXIS_MAX_BYTES = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

   // Lane 'lane' of an MSB-aligned keep holding 'cnt' bytes out of 'bytes' lanes.
   function automatic logic keep_lane(input int lane, input int cnt, input int bytes);
      return (lane < bytes) && (lane >= bytes - cnt);
   endfunction

   function automatic int keep_popcount(input logic [AXIS_MAX_BYTES-1:0] k);
      int n;
      n = 0;
      for (int i = 0; i < AXIS_MAX_BYTES; i++) begin
         if (k[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Combinational byte merge: splices h residual bytes in front of the top bytes of the
// incoming beat and works out keep/last for the merged beat and any trailing flush.
module axis_byte_merge
   import axis_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic [DATA_WD-1:0]      residual,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   input  logic [BYTE_CNT_WD:0]    hdr_bytes,
   output logic [DATA_WD-1:0]      merge_data,
   output logic [DATA_WD-1:0]      flush_data,
   output logic [DATA_BYTE_WD-1:0] merge_keep,
   output logic                    merge_last,
   output logic                    need_tail,
   output logic [BYTE_CNT_WD:0]    tail_bytes
);

   logic [AXIS_MAX_BYTES-1:0] keep_ext;
   int                        h;
   int                        n;
   int                        total;
   int                        keep_cnt;

   assign keep_ext = {{(AXIS_MAX_BYTES-DATA_BYTE_WD){1'b0}}, keep_in};

   always_comb begin
      h     = int'(hdr_bytes);
      // Only the last beat may be partial; earlier beats count as full.
      n     = last_in ? keep_popcount(keep_ext) : DATA_BYTE_WD;
      total = h + n;
      // Residual keeps its low h bytes, which move to the top of the beat.
      merge_data = (residual << ((DATA_BYTE_WD - h) * 8)) | (data_in >> (h * 8));
      flush_data = residual << ((DATA_BYTE_WD - h) * 8);
      merge_last = last_in && (total <= DATA_BYTE_WD);
      need_tail  = last_in && (total > DATA_BYTE_WD);
      keep_cnt   = merge_last ? total : DATA_BYTE_WD;
      tail_bytes = need_tail ? (BYTE_CNT_WD+1)'(total - DATA_BYTE_WD) : '0;
   end

   genvar gi;
   for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_keep
      assign merge_keep[gi] = keep_lane(gi, keep_cnt, DATA_BYTE_WD);
   end

endmodule

// File: rtl/axis_insert_header.sv
// AXI-Stream header inserter: prepends the valid bytes of one header word to each packet.
// Define AXIS_INSERT_HEADER_ZERO_FILL_EN to force output byte lanes with keep_out=0 to 0x00.
module axis_insert_header
   import axis_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   input  logic                    valid_insert,
   input  logic [DATA_WD-1:0]      data_insert,
   input  logic [DATA_BYTE_WD-1:0] keep_insert,
   input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
   output logic                    ready_insert
);

   state_t                  state_reg;
   state_t                  state_next;
   logic [DATA_WD-1:0]      residual_reg;
   logic [BYTE_CNT_WD:0]    hdr_bytes_reg;
   logic [BYTE_CNT_WD:0]    tail_bytes_reg;
   logic                    valid_out_reg;
   logic [DATA_WD-1:0]      data_out_reg;
   logic [DATA_BYTE_WD-1:0] keep_out_reg;
   logic                    last_out_reg;

   logic                    slot_free;
   logic                    hdr_take;
   logic                    beat_take;
   logic                    load;
   logic [DATA_WD-1:0]      load_data;
   logic [DATA_WD-1:0]      fill_data;
   logic [DATA_BYTE_WD-1:0] load_keep;
   logic                    load_last;
   logic [DATA_BYTE_WD-1:0] tail_keep;

   logic [DATA_WD-1:0]      merge_data;
   logic [DATA_WD-1:0]      flush_data;
   logic [DATA_BYTE_WD-1:0] merge_keep;
   logic                    merge_last;
   logic                    need_tail;
   logic [BYTE_CNT_WD:0]    tail_bytes;

   // The header byte count is authoritative; keep_insert carries no extra information.
   logic unused_keep_insert;
   assign unused_keep_insert = ^keep_insert;

   axis_byte_merge #(
      .DATA_WD      (DATA_WD),
      .DATA_BYTE_WD (DATA_BYTE_WD),
      .BYTE_CNT_WD  (BYTE_CNT_WD)
   ) u_merge (
      .residual   (residual_reg),
      .data_in    (data_in),
      .keep_in    (keep_in),
      .last_in    (last_in),
      .hdr_bytes  (hdr_bytes_reg),
      .merge_data (merge_data),
      .flush_data (flush_data),
      .merge_keep (merge_keep),
      .merge_last (merge_last),
      .need_tail  (need_tail),
      .tail_bytes (tail_bytes)
   );

   assign slot_free    = !valid_out_reg || ready_out;
   assign ready_insert = !rst && (state_reg == IDLE);
   assign ready_in     = !rst && (state_reg == DATA) && slot_free;

   genvar gi;
   for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_tail_keep
      assign tail_keep[gi] = keep_lane(gi, int'(tail_bytes_reg), DATA_BYTE_WD);
   end

`ifdef AXIS_INSERT_HEADER_ZERO_FILL_EN
   for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_fill
      assign fill_data[gi*8 +: 8] = load_keep[gi] ? load_data[gi*8 +: 8] : 8'h00;
   end
`else
   assign fill_data = load_data;
`endif

   always_comb begin
      state_next = state_reg;
      hdr_take   = 1'b0;
      beat_take  = 1'b0;
      load       = 1'b0;
      load_data  = merge_data;
      load_keep  = merge_keep;
      load_last  = merge_last;
      case (state_reg)
         IDLE: begin
            if (valid_insert && ready_insert) begin
               hdr_take   = 1'b1;
               state_next = DATA;
            end
         end
         DATA: begin
            if (valid_in && ready_in) begin
               beat_take = 1'b1;
               load      = 1'b1;
               if (last_in) state_next = need_tail ? TAIL : IDLE;
            end
         end
         TAIL: begin
            if (slot_free) begin
               load       = 1'b1;
               load_data  = flush_data;
               load_keep  = tail_keep;
               load_last  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         residual_reg   <= '0;
         hdr_bytes_reg  <= '0;
         tail_bytes_reg <= '0;
         valid_out_reg  <= 1'b0;
         data_out_reg   <= '0;
         keep_out_reg   <= '0;
         last_out_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (hdr_take) begin
            residual_reg  <= data_insert;
            hdr_bytes_reg <= {1'b0, byte_insert_cnt} + (BYTE_CNT_WD+1)'(1);
         end
         if (beat_take) begin
            residual_reg <= data_in;
            if (need_tail) tail_bytes_reg <= tail_bytes;
         end
         if (load) begin
            valid_out_reg <= 1'b1;
            data_out_reg  <= fill_data;
            keep_out_reg  <= load_keep;
            last_out_reg  <= load_last;
         end else if (ready_out) begin
            valid_out_reg <= 1'b0;
         end
      end
   end

   assign valid_out = valid_out_reg;
   assign data_out  = data_out_reg;
   assign keep_out  = keep_out_reg;
   assign last_out  = last_out_reg;

endmodule

// File: tb/tb_axis_insert_header.sv
// Self-checking bench for axis_insert_header: byte-queue reference model, directed and random packets.
module tb_axis_insert_header;

   localparam int DW = 32;
   localparam int BW = 4;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic [BW-1:0] keep_in;
   logic          last_in;
   logic          ready_in;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic [BW-1:0] keep_out;
   logic          last_out;
   logic          ready_out;
   logic          valid_insert;
   logic [DW-1:0] data_insert;
   logic [BW-1:0] keep_insert;
   logic [1:0]    byte_insert_cnt;
   logic          ready_insert;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   rnd_ready = 0;
   bit   hold_ready = 0;
   exp_t exp_q[$];
   int   pop_cyc[$];

   bit          held = 0;
   logic [31:0] held_data;
   logic [3:0]  held_keep;
   logic        held_last;

   axis_insert_header dut (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .keep_in         (keep_in),
      .last_in         (last_in),
      .ready_in        (ready_in),
      .valid_out       (valid_out),
      .data_out        (data_out),
      .keep_out        (keep_out),
      .last_out        (last_out),
      .ready_out       (ready_out),
      .valid_insert    (valid_insert),
      .data_insert     (data_insert),
      .keep_insert     (keep_insert),
      .byte_insert_cnt (byte_insert_cnt),
      .ready_insert    (ready_insert)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (hold_ready) ready_out = 1'b0;
      else if (rnd_ready) ready_out = 1'($urandom_range(0, 1));
      else ready_out = 1'b1;
   endtask

   // Reference model: the packet is just the header bytes followed by the payload bytes,
   // repacked MSB-first into 4-byte beats.
   task automatic expect_packet(input int cnt, input logic [31:0] hdr, input logic [7:0] bytes[$]);
      logic [7:0] all[$];
      exp_t       e;
      for (int i = cnt; i >= 0; i--) all.push_back(hdr[i*8 +: 8]);
      foreach (bytes[i]) all.push_back(bytes[i]);
      for (int p = 0; p < all.size(); p += BW) begin
         e.data = '0;
         e.keep = '0;
         for (int j = 0; j < BW && p + j < all.size(); j++) begin
            e.data[(BW-1-j)*8 +: 8] = all[p+j];
            e.keep[BW-1-j] = 1'b1;
         end
         e.last = (p + BW >= all.size());
         exp_q.push_back(e);
      end
   endtask

   task automatic send_header(input int cnt, input logic [31:0] hdr);
      int t;
      valid_insert    = 1'b1;
      data_insert     = hdr;
      byte_insert_cnt = 2'(cnt);
      keep_insert     = 4'(4'hF >> (3 - cnt));
      for (t = 0; t < 500; t++) begin
         @(negedge clk);
         if (ready_insert) break;
         step();
      end
      check("hdr_accept_timeout", 64'(t < 500), 64'd1);
      step();
      valid_insert = 1'b0;
   endtask

   task automatic send_beats(input logic [7:0] bytes[$], input bit mark_last);
      int nb;
      int t;
      nb = (bytes.size() + BW - 1) / BW;
      for (int b = 0; b < nb; b++) begin
         data_in = $urandom;
         keep_in = '0;
         for (int j = 0; j < BW; j++) begin
            if (b * BW + j < bytes.size()) begin
               data_in[(BW-1-j)*8 +: 8] = bytes[b*BW+j];
               keep_in[BW-1-j] = 1'b1;
            end
         end
         last_in  = mark_last && (b == nb - 1);
         valid_in = 1'b1;
         for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (ready_in) break;
            step();
         end
         check("beat_accept_timeout", 64'(t < 500), 64'd1);
         step();
      end
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic drain();
      int t;
      for (t = 0; t < 2000; t++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      check("drain_remaining", 64'(exp_q.size()), 64'd0);
   endtask

   // Output monitor: scoreboard compare on each handshake plus hold-stability checks.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] m;
      if (rst) begin
         held = 0;
      end else begin
         if (held) begin
            check("hold_valid", 64'(valid_out), 64'd1);
            check("hold_data", 64'(data_out), 64'(held_data));
            check("hold_keep", 64'(keep_out), 64'(held_keep));
            check("hold_last", 64'(last_out), 64'(held_last));
         end
         if (valid_out && !ready_out) check("ready_in_when_full", 64'(ready_in), 64'd0);
         if (valid_out && ready_out) begin
            $display("beat cyc=%0d data=%08h keep=%b last=%b", cyc, data_out, keep_out, last_out);
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               for (int j = 0; j < BW; j++) m[j*8 +: 8] = {8{e.keep[j]}};
               check("out_data", 64'(data_out & m), 64'(e.data));
               check("out_keep", 64'(keep_out), 64'(e.keep));
               check("out_last", 64'(last_out), 64'(e.last));
            end
            pop_cyc.push_back(cyc);
         end
         held      = valid_out && !ready_out;
         held_data = data_out;
         held_keep = keep_out;
         held_last = last_out;
      end
   end

   initial begin
      logic [7:0] bq[$];
      int         idx0;
      int         cnt;
      logic [31:0] hdr;

      rst = 1'b1;
      valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
      valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
      ready_out = 1'b1;
      step(); step(); step();

      // Reset state
      check("rst_valid_out", 64'(valid_out), 64'd0);
      check("rst_data_out", 64'(data_out), 64'd0);
      check("rst_keep_out", 64'(keep_out), 64'd0);
      check("rst_last_out", 64'(last_out), 64'd0);
      check("rst_ready_in", 64'(ready_in), 64'd0);
      check("rst_ready_insert", 64'(ready_insert), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready_insert", 64'(ready_insert), 64'd1);
      check("idle_ready_in", 64'(ready_in), 64'd0);
      step();

      // Two-byte header, residual absorbed by a short last beat
      bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      expect_packet(1, 32'hAABBCCDD, bq);
      send_header(1, 32'hAABBCCDD);
      send_beats(bq, 1'b1);
      drain();

      // Four-byte header, one-byte packet needs a tail beat
      bq = '{8'h11};
      expect_packet(3, 32'hA1A2A3A4, bq);
      send_header(3, 32'hA1A2A3A4);
      send_beats(bq, 1'b1);
      drain();

      // One-byte header, full last beat spills into a tail
      bq = '{8'h01, 8'h02, 8'h03, 8'h04};
      expect_packet(0, 32'h000000EE, bq);
      send_header(0, 32'h000000EE);
      send_beats(bq, 1'b1);
      drain();

      // Random backpressure on a 3-beat packet and a batch of random packets
      rnd_ready = 1;
      bq.delete();
      for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
      hdr = $urandom;
      expect_packet(2, hdr, bq);
      send_header(2, hdr);
      send_beats(bq, 1'b1);
      for (int p = 0; p < 10; p++) begin
         cnt = $urandom_range(0, 3);
         hdr = $urandom;
         bq.delete();
         for (int i = 0; i < int'($urandom_range(1, 13)); i++) bq.push_back(8'($urandom));
         expect_packet(cnt, hdr, bq);
         send_header(cnt, hdr);
         send_beats(bq, 1'b1);
      end
      drain();
      rnd_ready = 0;

      // Reset in the middle of a packet with an output beat parked
      hold_ready = 1;
      step();
      bq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      send_header(2, 32'h00B1B2B3);
      send_beats(bq, 1'b0);
      @(negedge clk);
      check("pre_rst_valid_out", 64'(valid_out), 64'd1);
      step();
      rst = 1'b1;
      step();
      check("mid_rst_valid_out", 64'(valid_out), 64'd0);
      check("mid_rst_keep_out", 64'(keep_out), 64'd0);
      check("mid_rst_last_out", 64'(last_out), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("post_rst_ready_insert", 64'(ready_insert), 64'd1);
      check("post_rst_valid_out", 64'(valid_out), 64'd0);
      hold_ready = 0;
      step();
      bq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
      expect_packet(1, 32'h0000E1E2, bq);
      send_header(1, 32'h0000E1E2);
      send_beats(bq, 1'b1);
      drain();

      // Back-to-back packets: next header offered while the last beat is on the output
      idx0 = pop_cyc.size();
      bq = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
      expect_packet(1, 32'h00001A1B, bq);
      send_header(1, 32'h00001A1B);
      send_beats(bq, 1'b1);
      bq = '{8'h31, 8'h32, 8'h33};
      expect_packet(0, 32'h0000002A, bq);
      send_header(0, 32'h0000002A);
      send_beats(bq, 1'b1);
      drain();
      check("b2b_beat_count", 64'(pop_cyc.size() - idx0), 64'd3);
      if (pop_cyc.size() - idx0 == 3)
         check("b2b_gap_le_2", 64'(pop_cyc[idx0+2] - pop_cyc[idx0+1] <= 2), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
